pll_lock_supervisor: RTL and testbench
======================================

// Module: pll_lock_supervisor
// PURPOSE
//   Supervises a PLL instance clocked from the same reference clock as the PLL.
//   - Drives the PLL reset and waits for lock, with timeout and bounded automatic retries.
//   - Qualifies lock as stable, then releases NUM_RST downstream resets in staged order.
//   - On loss of lock: re-asserts all downstream resets and re-runs the sequence.
//   Sits between the PLL wrapper and the video/VIP clock-domain reset synchronisers.
// PARAMETERS
//   NUM_RST          4      number of staged downstream reset outputs (1..16)
//   RST_PULSE_CYC    16     refclk cycles pll_rst is held high per PLL reset attempt (>=1)
//   LOCK_TIMEOUT_CYC 65536  refclk cycles allowed for first lock after pll_rst falls (>=2)
//   LOCK_STABLE_CYC  1024   consecutive synced-lock-high cycles required before release (>=1)
//   STAGE_GAP_CYC    8      refclk cycles between successive rst_out deassertions (>=1)
//   MAX_RETRIES      3      consecutive lock timeouts tolerated before entering FAIL (>=1)
// PORTS
//   refclk        in   1        reference clock; sole clock of this block
//   rst           in   1        asynchronous, active-high reset
//   pll_locked    in   1        PLL lock flag; asynchronous, 2-flop synchronised internally
//   retry         in   1        single-cycle pulse; leaves FAIL, ignored in all other states
//   pll_rst       out  1        PLL reset request, active-high
//   rst_out       out  NUM_RST  staged downstream resets, active-high; bit 0 is released first
//   all_ready     out  1        high only in RUN (every rst_out bit low)
//   fail          out  1        high in FAIL
//   lock_lost_cnt out  8        loss-of-lock events since rst; saturates at 255
// BEHAVIOUR
//   Outputs and sync
//   - All outputs are registered.
//   - Reset values: pll_rst=1, rst_out=all 1s, all_ready=0, fail=0, lock_lost_cnt=0;
//     state=RESET_PLL, all counters=0, retry count=0.
//   - lk = pll_locked after the 2-flop synchroniser: 2 cycles latency.
//   FSM (one cycle counter, cleared on every state entry)
//   - RESET_PLL: pll_rst=1, rst_out=all 1s.
//     -> WAIT_LOCK after RST_PULSE_CYC cycles.
//   - WAIT_LOCK: pll_rst=0.
//     - lk=1 -> STABLE.
//     - Counter reaches LOCK_TIMEOUT_CYC: retry count+1.
//       - New retry count == MAX_RETRIES -> FAIL.
//       - Otherwise -> RESET_PLL.
//   - STABLE: counts consecutive lk=1 cycles.
//     - lk=0 -> WAIT_LOCK. This is not a lock-loss event and does not advance the retry count.
//     - Count reaches LOCK_STABLE_CYC -> RELEASE; retry count cleared.
//   - RELEASE: rst_out[k] falls on cycle k*STAGE_GAP_CYC after entry (k=0 falls on the entry cycle).
//     - Once rst_out[NUM_RST-1] has fallen, -> RUN on the next cycle.
//   - RUN: all_ready=1.
//   - Lock loss in RELEASE or RUN (lk=0):
//     - Next registered edge: rst_out=all 1s, all_ready=0, pll_rst=1.
//     - lock_lost_cnt+1, saturating; state -> RESET_PLL.
//   - FAIL: pll_rst=1, rst_out=all 1s, fail=1.
//     - lk is ignored.
//     - retry=1 -> RESET_PLL; fail=0 and retry count cleared.
//   Boundary and priority rules
//   - retry and lk changes in the same cycle: state-specific rule above applies; no other interaction.
//   - lk=0 on the same cycle a stage or stable count completes: lock loss wins.
//   - rst asserted mid-sequence: immediate async return to reset values.
//     lock_lost_cnt is cleared only by rst.
//   - A retry pulse outside FAIL has no effect.
//   - rst_out is never partially re-released; once any bit re-asserts, all bits do.
// TESTING  (NUM_RST=3, RST_PULSE_CYC=4, LOCK_TIMEOUT_CYC=32, LOCK_STABLE_CYC=8, STAGE_GAP_CYC=2,
//           MAX_RETRIES=2)
//   1 Power-up: release rst, pll_locked=1 at cycle 6.
//     -> pll_rst high for cycles 0-3; rst_out 3'b111 -> 3'b110 -> 3'b100 -> 3'b000 at 2-cycle gaps;
//        all_ready=1; lock_lost_cnt=0.
//   2 Lock glitch in STABLE: drop pll_locked for 1 cycle after 5 high cycles.
//     -> STABLE count restarts; release begins only after 8 fresh consecutive lk cycles;
//        no lock_lost_cnt change.
//   3 Loss in RUN: drop pll_locked.
//     -> rst_out=3'b111, all_ready=0, pll_rst=1 within 3 cycles of the drop; lock_lost_cnt=1;
//        full sequence repeats after relock.
//   4 Never lock.
//     -> two 4-cycle pll_rst pulses separated by 32-cycle waits, then fail=1 with pll_rst held high;
//        a retry pulse restarts with fail=0.
//   5 Saturation: 300 loss/relock cycles -> lock_lost_cnt stops at 255.
//   6 Async rst during RELEASE with rst_out=3'b100.
//     -> all outputs take reset values immediately, before the next clock edge.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor: pulses the PLL reset, waits for lock with
// bounded retries, qualifies lock, then releases downstream resets in order.
module pll_lock_supervisor #(
   parameter int NUM_RST          = 4,
   parameter int RST_PULSE_CYC    = 16,
   parameter int LOCK_TIMEOUT_CYC = 65536,
   parameter int LOCK_STABLE_CYC  = 1024,
   parameter int STAGE_GAP_CYC    = 8,
   parameter int MAX_RETRIES      = 3
) (
   input  logic               refclk,
   input  logic               rst,
   input  logic               pll_locked,
   input  logic               retry,
   output logic               pll_rst,
   output logic [NUM_RST-1:0] rst_out,
   output logic               all_ready,
   output logic               fail,
   output logic [7:0]         lock_lost_cnt
);

   localparam int CW = $clog2(LOCK_TIMEOUT_CYC + RST_PULSE_CYC + LOCK_STABLE_CYC
                              + NUM_RST * STAGE_GAP_CYC + 1);
   localparam int RW = $clog2(MAX_RETRIES + 1);

   localparam logic [CW-1:0] PULSE_END   = CW'(RST_PULSE_CYC - 1);
   localparam logic [CW-1:0] TIMEOUT_END = CW'(LOCK_TIMEOUT_CYC - 1);
   localparam logic [CW-1:0] STABLE_END  = CW'(LOCK_STABLE_CYC - 1);
   localparam logic [CW-1:0] RELEASE_END = CW'((NUM_RST - 1) * STAGE_GAP_CYC);
   localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);

   typedef enum logic [2:0] {
      S_RESET_PLL,
      S_WAIT_LOCK,
      S_STABLE,
      S_RELEASE,
      S_RUN,
      S_FAIL
   } state_e;

   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [RW-1:0]      retry_cnt_q, retry_cnt_d;
   logic               sync1_q, sync2_q;
   logic               pll_rst_q, pll_rst_d;
   logic [NUM_RST-1:0] rst_out_q, rst_out_d;
   logic               all_ready_q, all_ready_d;
   logic               fail_q, fail_d;
   logic [7:0]         lost_q, lost_d;
   logic               lk;
   logic               lost_evt;

   assign lk = sync2_q;

   always_comb begin : fsm_next
      state_d     = state_q;
      retry_cnt_d = retry_cnt_q;
      lost_evt    = 1'b0;
      unique case (state_q)
         S_RESET_PLL: begin
            if (cnt_q == PULSE_END) state_d = S_WAIT_LOCK;
         end
         S_WAIT_LOCK: begin
            if (lk) begin
               state_d = S_STABLE;
            end else if (cnt_q == TIMEOUT_END) begin
               retry_cnt_d = retry_cnt_q + RW'(1);
               state_d     = (retry_cnt_d == RETRY_MAX) ? S_FAIL : S_RESET_PLL;
            end
         end
         S_STABLE: begin
            // a dropout here is just a failed qualification, not a lock loss
            if (!lk) begin
               state_d = S_WAIT_LOCK;
            end else if (cnt_q == STABLE_END) begin
               state_d     = S_RELEASE;
               retry_cnt_d = '0;
            end
         end
         S_RELEASE: begin
            if (!lk) begin
               state_d  = S_RESET_PLL;
               lost_evt = 1'b1;
            end else if (cnt_q == RELEASE_END) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (!lk) begin
               state_d  = S_RESET_PLL;
               lost_evt = 1'b1;
            end
         end
         S_FAIL: begin
            if (retry) begin
               state_d     = S_RESET_PLL;
               retry_cnt_d = '0;
            end
         end
         default: state_d = S_RESET_PLL;
      endcase
   end

   // outputs are decoded from the next state so they register with it
   always_comb begin : out_next
      cnt_d = cnt_q;
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (state_d != S_RUN && state_d != S_FAIL) begin
         cnt_d = cnt_q + CW'(1);
      end
      pll_rst_d   = (state_d == S_RESET_PLL) || (state_d == S_FAIL);
      fail_d      = (state_d == S_FAIL);
      all_ready_d = (state_d == S_RUN);
      rst_out_d   = '1;
      if (state_d == S_RUN) begin
         rst_out_d = '0;
      end else if (state_d == S_RELEASE) begin
         for (int k = 0; k < NUM_RST; k++) begin
            if (cnt_d >= CW'(k * STAGE_GAP_CYC)) rst_out_d[k] = 1'b0;
         end
      end
      lost_d = lost_q;
      if (lost_evt && lost_q != 8'hFF) lost_d = lost_q + 8'd1;
   end

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         state_q     <= S_RESET_PLL;
         cnt_q       <= '0;
         retry_cnt_q <= '0;
         pll_rst_q   <= 1'b1;
         rst_out_q   <= '1;
         all_ready_q <= 1'b0;
         fail_q      <= 1'b0;
         lost_q      <= 8'd0;
      end else begin
         sync1_q     <= pll_locked;
         sync2_q     <= sync1_q;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_cnt_q <= retry_cnt_d;
         pll_rst_q   <= pll_rst_d;
         rst_out_q   <= rst_out_d;
         all_ready_q <= all_ready_d;
         fail_q      <= fail_d;
         lost_q      <= lost_d;
      end
   end

   assign pll_rst       = pll_rst_q;
   assign rst_out       = rst_out_q;
   assign all_ready     = all_ready_q;
   assign fail          = fail_q;
   assign lock_lost_cnt = lost_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed scenarios plus random lock
// activity, checked cycle by cycle against a phase/age reference model.
`timescale 1ns/1ps
module tb_pll_lock_supervisor;

   localparam int N    = 3;
   localparam int PULSE = 4;
   localparam int TMO  = 32;
   localparam int STB  = 8;
   localparam int GAP  = 2;
   localparam int MAXR = 2;

   localparam int P_PULSE = 0;
   localparam int P_WAIT  = 1;
   localparam int P_QUAL  = 2;
   localparam int P_STAGE = 3;
   localparam int P_UP    = 4;
   localparam int P_DEAD  = 5;

   localparam logic [13:0] RST_VEC = {1'b1, 3'b111, 1'b0, 1'b0, 8'd0};

   logic         refclk = 1'b0;
   logic         rst = 1'b1;
   logic         pll_locked = 1'b0;
   logic         retry = 1'b0;
   logic         pll_rst;
   logic [N-1:0] rst_out;
   logic         all_ready;
   logic         fail;
   logic [7:0]   lock_lost_cnt;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   int m_phase, m_age, m_tries, m_lost;
   bit m_s1, m_s2;

   wire [13:0] obs = {pll_rst, rst_out, all_ready, fail, lock_lost_cnt};

   pll_lock_supervisor #(
      .NUM_RST(N), .RST_PULSE_CYC(PULSE), .LOCK_TIMEOUT_CYC(TMO),
      .LOCK_STABLE_CYC(STB), .STAGE_GAP_CYC(GAP), .MAX_RETRIES(MAXR)
   ) dut (
      .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .retry(retry),
      .pll_rst(pll_rst), .rst_out(rst_out), .all_ready(all_ready),
      .fail(fail), .lock_lost_cnt(lock_lost_cnt)
   );

   always #5 refclk = ~refclk;

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   function automatic logic [13:0] exp_vec();
      logic [N-1:0] ro;
      ro = '1;
      if (m_phase == P_UP) ro = '0;
      else if (m_phase == P_STAGE)
         for (int k = 0; k < N; k++) if (m_age >= k * GAP) ro[k] = 1'b0;
      return {(m_phase == P_PULSE || m_phase == P_DEAD), ro,
              (m_phase == P_UP), (m_phase == P_DEAD), 8'(m_lost)};
   endfunction

   task automatic model_reset();
      m_phase = P_PULSE;
      m_age = 0;
      m_tries = 0;
      m_lost = 0;
      m_s1 = 0;
      m_s2 = 0;
   endtask

   task automatic model_lose();
      m_phase = P_PULSE;
      m_age = 0;
      if (m_lost < 255) m_lost++;
   endtask

   task automatic model_step();
      bit lk;
      lk = m_s2;
      m_s2 = m_s1;
      m_s1 = pll_locked;
      case (m_phase)
         P_PULSE: begin
            m_age++;
            if (m_age == PULSE) begin m_phase = P_WAIT; m_age = 0; end
         end
         P_WAIT: begin
            if (lk) begin
               m_phase = P_QUAL; m_age = 0;
            end else begin
               m_age++;
               if (m_age == TMO) begin
                  m_tries++;
                  m_age = 0;
                  m_phase = (m_tries == MAXR) ? P_DEAD : P_PULSE;
               end
            end
         end
         P_QUAL: begin
            if (!lk) begin
               m_phase = P_WAIT; m_age = 0;
            end else begin
               m_age++;
               if (m_age == STB) begin m_phase = P_STAGE; m_age = 0; m_tries = 0; end
            end
         end
         P_STAGE: begin
            if (!lk) model_lose();
            else if (m_age == (N - 1) * GAP) begin m_phase = P_UP; m_age = 0; end
            else m_age++;
         end
         P_UP: if (!lk) model_lose();
         default: if (retry) begin m_phase = P_PULSE; m_age = 0; m_tries = 0; end
      endcase
   endtask

   task automatic tick();
      @(posedge refclk);
      model_step();
      cyc++;
      @(negedge refclk);
   endtask

   task automatic do_reset();
      @(negedge refclk);
      rst = 1'b1;
      retry = 1'b0;
      @(negedge refclk);
      model_reset();
      rst = 1'b0;
      cyc = 0;
   endtask

   task automatic test_reset();
      @(negedge refclk);
      pll_locked = 1'b1;
      @(negedge refclk);
      model_reset();
      if (obs !== RST_VEC) begin
         bad++; $display("FAIL reset_values: got %h want %h", obs, RST_VEC);
      end
      total++;
      rst = 1'b0;
      cyc = 0;
      tick();
      if (obs !== exp_vec()) begin
         bad++; $display("FAIL reset_first_cycle: got %h want %h", obs, exp_vec());
      end
      total++;
   endtask

   task automatic test_power_up();
      int n_rst = 0, t110 = -1, t100 = -1, t000 = -1;
      pll_locked = 1'b0;
      do_reset();
      for (int i = 0; i < 40; i++) begin
         if (obs !== exp_vec()) begin
            bad++;
            if (bad < 20) $display("FAIL pwr_c%0d: got %h want %h", cyc, obs, exp_vec());
         end
         total++;
         if (pll_rst) n_rst++;
         if (rst_out === 3'b110 && t110 < 0) t110 = cyc;
         if (rst_out === 3'b100 && t100 < 0) t100 = cyc;
         if (rst_out === 3'b000 && t000 < 0) t000 = cyc;
         pll_locked = (cyc >= 5);
         tick();
      end
      if (n_rst !== 4) begin
         bad++; $display("FAIL pwr_pll_rst_len: got %0d want 4", n_rst);
      end
      total++;
      if (t110 < 0 || t100 - t110 !== GAP || t000 - t100 !== GAP) begin
         bad++; $display("FAIL pwr_stage_gaps: got %0d/%0d/%0d want gaps of 2", t110, t100, t000);
      end
      total++;
      if ({all_ready, pll_rst, lock_lost_cnt} !== {1'b1, 1'b0, 8'd0}) begin
         bad++; $display("FAIL pwr_final: got %b %b %0d want 1 0 0", all_ready, pll_rst, lock_lost_cnt);
      end
      total++;
   endtask

   task automatic test_glitch();
      int g = -1, t110 = -1;
      pll_locked = 1'b1;
      do_reset();
      for (int i = 0; i < 50; i++) begin
         if (obs !== exp_vec()) begin
            bad++;
            if (bad < 20) $display("FAIL glitch_c%0d: got %h want %h", cyc, obs, exp_vec());
         end
         total++;
         if (g >= 0 && rst_out === 3'b110 && t110 < 0) t110 = cyc;
         pll_locked = 1'b1;
         if (g < 0 && m_phase == P_QUAL && m_age == 3) begin
            pll_locked = 1'b0;
            g = cyc;
         end
         tick();
      end
      if (t110 < g + 11) begin
         bad++; $display("FAIL glitch_requalify: got release at %0d want >= %0d", t110, g + 11);
      end
      total++;
      if ({all_ready, lock_lost_cnt} !== {1'b1, 8'd0}) begin
         bad++; $display("FAIL glitch_no_loss: got %b %0d want 1 0", all_ready, lock_lost_cnt);
      end
      total++;
   endtask

   task automatic test_loss_run();
      pll_locked = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      if ({pll_rst, rst_out, all_ready, lock_lost_cnt} !== {1'b1, 3'b111, 1'b0, 8'd1}) begin
         bad++;
         $display("FAIL loss_reassert: got %b %b %b %0d want 1 111 0 1",
                  pll_rst, rst_out, all_ready, lock_lost_cnt);
      end
      total++;
      pll_locked = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (obs !== exp_vec()) begin
            bad++;
            if (bad < 20) $display("FAIL loss_c%0d: got %h want %h", cyc, obs, exp_vec());
         end
         total++;
         tick();
      end
      if ({all_ready, lock_lost_cnt} !== {1'b1, 8'd1}) begin
         bad++; $display("FAIL loss_relock: got %b %0d want 1 1", all_ready, lock_lost_cnt);
      end
      total++;
   endtask

   task automatic test_never_lock();
      int n_low = 0;
      pll_locked = 1'b0;
      do_reset();
      for (int i = 0; i < 90; i++) begin
         if (obs !== exp_vec()) begin
            bad++;
            if (bad < 20) $display("FAIL nolock_c%0d: got %h want %h", cyc, obs, exp_vec());
         end
         total++;
         if (!pll_rst) n_low++;
         pll_locked = (cyc >= 75);
         tick();
      end
      if (n_low !== 2 * TMO) begin
         bad++; $display("FAIL nolock_waits: got %0d low cycles want %0d", n_low, 2 * TMO);
      end
      total++;
      if ({fail, pll_rst, rst_out} !== {1'b1, 1'b1, 3'b111}) begin
         bad++; $display("FAIL nolock_fail: got %b %b %b want 1 1 111", fail, pll_rst, rst_out);
      end
      total++;
      retry = 1'b1;
      tick();
      retry = 1'b0;
      if ({fail, pll_rst} !== {1'b0, 1'b1}) begin
         bad++; $display("FAIL nolock_retry: got %b %b want 0 1", fail, pll_rst);
      end
      total++;
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 24 + 25 * 300 + 10; i++) begin
         pll_locked = (cyc % 25 != 24);
         if (obs !== exp_vec()) begin
            bad++;
            if (bad < 20) $display("FAIL sat_c%0d: got %h want %h", cyc, obs, exp_vec());
         end
         total++;
         tick();
      end
      if (lock_lost_cnt !== 8'd255) begin
         bad++; $display("FAIL sat_count: got %0d want 255", lock_lost_cnt);
      end
      total++;
   endtask

   task automatic test_async_reset();
      bit hit = 0;
      pll_locked = 1'b1;
      do_reset();
      for (int i = 0; i < 60 && !hit; i++) begin
         if (obs !== exp_vec()) begin
            bad++;
            if (bad < 20) $display("FAIL arst_c%0d: got %h want %h", cyc, obs, exp_vec());
         end
         total++;
         if (exp_vec() == {1'b0, 3'b100, 1'b0, 1'b0, 8'd0}) hit = 1;
         else tick();
      end
      if (!hit) begin
         bad++; $display("FAIL arst_reach: got no 100 stage want rst_out=100");
      end
      total++;
      #2 rst = 1'b1;
      #1;
      if (obs !== RST_VEC) begin
         bad++; $display("FAIL arst_immediate: got %h want %h", obs, RST_VEC);
      end
      total++;
      @(negedge refclk);
      model_reset();
      rst = 1'b0;
      cyc = 0;
   endtask

   task automatic test_random();
      do_reset();
      pll_locked = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (obs !== exp_vec()) begin
            bad++;
            if (bad < 20) $display("FAIL rand_c%0d: got %h want %h", cyc, obs, exp_vec());
         end
         total++;
         if (pll_locked ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 44) == 0))
            pll_locked = ~pll_locked;
         retry = ($urandom_range(0, 29) == 0);
         tick();
      end
      retry = 1'b0;
   endtask

   initial begin
      test_reset();
      test_power_up();
      test_glitch();
      test_loss_run();
      test_never_lock();
      test_saturation();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
